// File: rtl/tone_pkg.sv
// Shared definitions for the tone oscillator channel.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Contents: register addresses, CTRL bit positions, wave type encodings,
// and the length-counter state type.
package tone_pkg;

    // Register port addresses
    localparam logic [1:0] REG_FREQ_LO = 2'd0;
    localparam logic [1:0] REG_FREQ_HI = 2'd1;
    localparam logic [1:0] REG_CTRL    = 2'd2;
    localparam logic [1:0] REG_LENGTH  = 2'd3;

    // CTRL register bit positions
    localparam int CTRL_TYPE_LSB = 0;
    localparam int CTRL_TYPE_MSB = 2;
    localparam int CTRL_ENABLE   = 3;
    localparam int CTRL_LEN_EN   = 4;
    localparam int CTRL_KEY_ON   = 5;

    // Wave types understood by the downstream LUT
    typedef enum logic [2:0] {
        WAVE_SQ_D0      = 3'd0,
        WAVE_SQ_D1      = 3'd1,
        WAVE_SQ_D2      = 3'd2,
        WAVE_SQ_D3      = 3'd3,
        WAVE_MEM_NORMAL = 3'd4,
        WAVE_MEM_RANDOM = 3'd5,
        WAVE_MEM_FIRST  = 3'd6,
        WAVE_MEM_SECOND = 3'd7
    } wave_t;

    // Channel state: IDLE is silent/frozen, RUN advances phase and length
    typedef enum logic {
        LEN_IDLE = 1'b0,
        LEN_RUN  = 1'b1
    } len_state_t;

endpackage

// File: rtl/tone_length_ctr.sv
// Note-length counter and channel active flag (IDLE/RUN state machine).
// Latency: load/expiry take effect on the clock edge they are sampled; active is registered.
// Backpressure: none; load and tick are accepted every cycle.
//
// Ports: clk_in, reset_n_in (async active-low), load (key_on strobe),
//        tick (sample strobe), length_en, length_val (reload value),
//        active (channel running).
module tone_length_ctr
    import tone_pkg::*;
(
    input  logic       clk_in,
    input  logic       reset_n_in,
    input  logic       load,
    input  logic       tick,
    input  logic       length_en,
    input  logic [7:0] length_val,
    output logic       active
);

    len_state_t state;
    len_state_t state_nxt;
    logic [7:0] len_cnt;
    logic       count_step;
    logic       expire;

    // A zero count never decrements, which is what makes length 0 mean "infinite".
    assign count_step = tick && (state == LEN_RUN) && length_en && (len_cnt != 8'd0);
    assign expire     = count_step && (len_cnt == 8'd1);

    // State register
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state <= LEN_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a load always (re)starts the channel, even on the expiry tick.
    always_comb begin
        state_nxt = state;
        case (state)
            LEN_IDLE: if (load) state_nxt = LEN_RUN;
            LEN_RUN: begin
                if (load) begin
                    state_nxt = LEN_RUN;
                end else if (expire) begin
                    state_nxt = LEN_IDLE;
                end
            end
        endcase
    end

    // Output
    always_comb begin
        active = (state == LEN_RUN);
    end

    // Count register
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            len_cnt <= 8'd0;
        end else if (load) begin
            len_cnt <= length_val;
        end else if (count_step) begin
            len_cnt <= len_cnt - 8'd1;
        end
    end

endmodule

// File: rtl/tone_osc.sv
// Single-channel tone oscillator: register file, phase accumulator, LUT address/gate/wrap.
// Latency: a tick or register write sampled at edge N is visible on outputs from cycle N+1.
// Backpressure: none; register writes and ticks are accepted every cycle without stall.
//
// Ports: clk_in, reset_n_in (async active-low), tick_in, reg_addr_in[1:0],
//        reg_data_in[7:0], reg_write_en_in, lut_addr_out[4:0], wave_type_out[2:0],
//        gate_out, wrap_out.
module tone_osc
    import tone_pkg::*;
#(
    parameter int ACC_WIDTH = 20
)
(
    input  logic       clk_in,
    input  logic       reset_n_in,
    input  logic       tick_in,
    input  logic [1:0] reg_addr_in,
    input  logic [7:0] reg_data_in,
    input  logic       reg_write_en_in,
    output logic [4:0] lut_addr_out,
    output logic [2:0] wave_type_out,
    output logic       gate_out,
    output logic       wrap_out
);

    localparam int SUM_W = ACC_WIDTH + 1;

    logic [7:0]           shadow_lo;
    logic [15:0]          freq;
    wave_t                wave_type;
    logic                 enable;
    logic                 length_en;
    logic [7:0]           length_reg;
    logic [ACC_WIDTH-1:0] acc;
    logic                 wrap;
    logic                 active;

    logic                 wr_lo;
    logic                 wr_hi;
    logic                 wr_ctrl;
    logic                 wr_len;
    logic                 key_on;
    logic [SUM_W-1:0]     acc_sum;

    // Register decode
    assign wr_lo   = reg_write_en_in && (reg_addr_in == REG_FREQ_LO);
    assign wr_hi   = reg_write_en_in && (reg_addr_in == REG_FREQ_HI);
    assign wr_ctrl = reg_write_en_in && (reg_addr_in == REG_CTRL);
    assign wr_len  = reg_write_en_in && (reg_addr_in == REG_LENGTH);
    assign key_on  = wr_ctrl && reg_data_in[CTRL_KEY_ON];

    // Extra top bit of the sum is the wrap carry.
    assign acc_sum = {1'b0, acc} + SUM_W'(freq);

    // Register file. freq only changes on the HI write so the 16-bit update is atomic;
    // a tick in the same cycle still sees the old freq through acc_sum.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            shadow_lo  <= 8'd0;
            freq       <= 16'd0;
            wave_type  <= WAVE_SQ_D0;
            enable     <= 1'b0;
            length_en  <= 1'b0;
            length_reg <= 8'd0;
        end else begin
            if (wr_lo) begin
                shadow_lo <= reg_data_in;
            end
            if (wr_hi) begin
                freq <= {reg_data_in, shadow_lo};
            end
            if (wr_ctrl) begin
                wave_type <= wave_t'(reg_data_in[CTRL_TYPE_MSB:CTRL_TYPE_LSB]);
                enable    <= reg_data_in[CTRL_ENABLE];
                length_en <= reg_data_in[CTRL_LEN_EN];
            end
            if (wr_len) begin
                length_reg <= reg_data_in;
            end
        end
    end

    // Phase accumulator. key_on beats a coincident tick: phase restarts with no wrap.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            acc  <= '0;
            wrap <= 1'b0;
        end else if (key_on) begin
            acc  <= '0;
            wrap <= 1'b0;
        end else if (tick_in && active) begin
            acc  <= acc_sum[ACC_WIDTH-1:0];
            wrap <= acc_sum[ACC_WIDTH];
        end else begin
            wrap <= 1'b0;
        end
    end

    // length_en here is the stored value; on key_on the load takes priority anyway.
    tone_length_ctr u_length_ctr (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .load       (key_on),
        .tick       (tick_in),
        .length_en  (length_en),
        .length_val (length_reg),
        .active     (active)
    );

    assign lut_addr_out  = acc[ACC_WIDTH-1 -: 5];
    assign wave_type_out = wave_type;
    assign gate_out      = enable && active;
    assign wrap_out      = wrap;

endmodule

// File: tb/tb_tone_osc.sv
// Self-checking bench for tone_osc: directed scenarios plus randomized traffic
// checked against a behavioural channel model.
// Clock 10 ns; inputs driven at negedge, outputs sampled 1 ns after posedge.
module tb_tone_osc;

    logic       clk_in = 1'b0;
    logic       reset_n_in = 1'b0;
    logic       tick_in = 1'b0;
    logic [1:0] reg_addr_in = 2'd0;
    logic [7:0] reg_data_in = 8'd0;
    logic       reg_write_en_in = 1'b0;
    logic [4:0] lut_addr_out;
    logic [2:0] wave_type_out;
    logic       gate_out;
    logic       wrap_out;

    int errors = 0;
    int checks = 0;

    localparam longint ACC_MOD = 64'd1 << 20;

    // Behavioural channel model
    longint m_acc;
    int     m_freq, m_shadow, m_type, m_len_reg, m_len_cnt;
    bit     m_en, m_len_en, m_active, m_wrap;

    tone_osc #(.ACC_WIDTH(20)) dut (
        .clk_in          (clk_in),
        .reset_n_in      (reset_n_in),
        .tick_in         (tick_in),
        .reg_addr_in     (reg_addr_in),
        .reg_data_in     (reg_data_in),
        .reg_write_en_in (reg_write_en_in),
        .lut_addr_out    (lut_addr_out),
        .wave_type_out   (wave_type_out),
        .gate_out        (gate_out),
        .wrap_out        (wrap_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic model_reset();
        m_acc = 0; m_freq = 0; m_shadow = 0; m_type = 0; m_len_reg = 0;
        m_len_cnt = 0; m_en = 0; m_len_en = 0; m_active = 0; m_wrap = 0;
    endtask

    // One clock of channel behaviour: tick effects use the pre-write settings,
    // then the register write lands; key_on overrides any tick effect.
    task automatic model_cycle(input bit t, input bit we, input bit [1:0] a, input bit [7:0] d);
        bit kon;
        kon = we && (a == 2'd2) && d[5];
        m_wrap = 0;
        if (t && m_active && !kon) begin
            m_wrap = (m_acc + m_freq) >= ACC_MOD;
            m_acc  = (m_acc + m_freq) % ACC_MOD;
            if (m_len_en && m_len_cnt != 0) begin
                m_len_cnt = m_len_cnt - 1;
                if (m_len_cnt == 0) m_active = 0;
            end
        end
        if (we) begin
            case (a)
                2'd0: m_shadow = d;
                2'd1: m_freq = d * 256 + m_shadow;
                2'd2: begin
                    m_type   = d & 7;
                    m_en     = d[3];
                    m_len_en = d[4];
                    if (kon) begin
                        m_acc = 0; m_active = 1; m_len_cnt = m_len_reg;
                    end
                end
                default: m_len_reg = d;
            endcase
        end
    endtask

    // Drive one cycle of stimulus; returns 1 ns after the sampling edge.
    task automatic drive(input bit t, input bit we, input bit [1:0] a, input bit [7:0] d);
        @(negedge clk_in);
        tick_in = t; reg_write_en_in = we; reg_addr_in = a; reg_data_in = d;
        @(posedge clk_in);
        model_cycle(t, we, a, d);
        #1;
        tick_in = 1'b0; reg_write_en_in = 1'b0;
    endtask

    task automatic set_freq(input bit [15:0] f);
        drive(0, 1, 2'd0, f[7:0]);
        drive(0, 1, 2'd1, f[15:8]);
    endtask

    task automatic test_reset();
        #3;
        checks++; if (lut_addr_out !== 5'd0) begin errors++; $display("FAIL reset_lut got=%0d exp=0", lut_addr_out); end
        checks++; if (wave_type_out !== 3'd0) begin errors++; $display("FAIL reset_type got=%0d exp=0", wave_type_out); end
        checks++; if (gate_out !== 1'b0) begin errors++; $display("FAIL reset_gate got=%b exp=0", gate_out); end
        checks++; if (wrap_out !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", wrap_out); end
        model_reset();
        @(negedge clk_in);
        reset_n_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 2'd0, 8'd0);
            checks++; if (lut_addr_out !== 5'd0) begin errors++; $display("FAIL reset_idle_tick got=%0d exp=0", lut_addr_out); end
        end
    endtask

    task automatic test_rate();
        set_freq(16'h1000);
        drive(0, 1, 2'd2, 8'h28);
        checks++; if (gate_out !== 1'b1) begin errors++; $display("FAIL rate_gate got=%b exp=1", gate_out); end
        for (int k = 1; k <= 256; k++) begin
            drive(1, 0, 2'd0, 8'd0);
            checks++;
            if (lut_addr_out !== 5'((k / 8) % 32)) begin
                errors++; $display("FAIL rate_lut tick=%0d got=%0d exp=%0d", k, lut_addr_out, (k / 8) % 32);
            end
            checks++;
            if (wrap_out !== (k == 256)) begin
                errors++; $display("FAIL rate_wrap tick=%0d got=%b exp=%b", k, wrap_out, (k == 256));
            end
        end
        drive(0, 0, 2'd0, 8'd0);
        checks++; if (wrap_out !== 1'b0) begin errors++; $display("FAIL rate_wrap_width got=%b exp=0", wrap_out); end
    endtask

    task automatic test_atomic_freq();
        int exp_lut;
        set_freq(16'h4000);
        drive(0, 1, 2'd2, 8'h28);
        drive(0, 1, 2'd0, 8'h34);
        for (int k = 1; k <= 5; k++) begin
            drive(1, 0, 2'd0, 8'd0);
            checks++;
            if (lut_addr_out !== 5'(k / 2)) begin
                errors++; $display("FAIL atomic_old_step tick=%0d got=%0d exp=%0d", k, lut_addr_out, k / 2);
            end
        end
        // HI write coincident with a tick: that tick still adds 0x4000 (acc 0x18000)
        drive(1, 1, 2'd1, 8'h12);
        checks++; if (lut_addr_out !== 5'd3) begin errors++; $display("FAIL atomic_coincident got=%0d exp=3", lut_addr_out); end
        for (int n = 1; n <= 8; n++) begin
            drive(1, 0, 2'd0, 8'd0);
            exp_lut = ((32'h18000 + n * 32'h1234) >> 15) & 31;
            checks++;
            if (lut_addr_out !== 5'(exp_lut)) begin
                errors++; $display("FAIL atomic_new_step n=%0d got=%0d exp=%0d", n, lut_addr_out, exp_lut);
            end
        end
    endtask

    task automatic test_length();
        set_freq(16'h8000);
        drive(0, 1, 2'd3, 8'd3);
        drive(0, 1, 2'd2, 8'h3C);
        checks++; if (gate_out !== 1'b1) begin errors++; $display("FAIL len_gate_start got=%b exp=1", gate_out); end
        checks++; if (wave_type_out !== 3'd4) begin errors++; $display("FAIL len_type got=%0d exp=4", wave_type_out); end
        for (int k = 1; k <= 6; k++) begin
            drive(1, 0, 2'd0, 8'd0);
            checks++;
            if (gate_out !== (k < 3)) begin
                errors++; $display("FAIL len_gate tick=%0d got=%b exp=%b", k, gate_out, (k < 3));
            end
            checks++;
            if (lut_addr_out !== 5'((k < 3) ? k : 3)) begin
                errors++; $display("FAIL len_acc tick=%0d got=%0d exp=%0d", k, lut_addr_out, (k < 3) ? k : 3);
            end
        end
        drive(0, 1, 2'd3, 8'd0);
        drive(0, 1, 2'd2, 8'h3C);
        for (int k = 1; k <= 1000; k++) begin
            drive(1, 0, 2'd0, 8'd0);
            checks++;
            if (gate_out !== 1'b1) begin errors++; $display("FAIL len_infinite tick=%0d got=%b exp=1", k, gate_out); end
        end
    endtask

    task automatic test_collisions();
        set_freq(16'hFFFF);
        drive(0, 1, 2'd2, 8'h28);
        for (int k = 0; k < 16; k++) drive(1, 0, 2'd0, 8'd0);
        set_freq(16'h000F);
        drive(1, 0, 2'd0, 8'd0);
        checks++; if (lut_addr_out !== 5'd31) begin errors++; $display("FAIL coll_setup got=%0d exp=31", lut_addr_out); end
        drive(1, 1, 2'd2, 8'h28);
        checks++; if (lut_addr_out !== 5'd0) begin errors++; $display("FAIL coll_keyon_lut got=%0d exp=0", lut_addr_out); end
        checks++; if (wrap_out !== 1'b0) begin errors++; $display("FAIL coll_keyon_wrap got=%b exp=0", wrap_out); end
        set_freq(16'h8000);
        drive(0, 1, 2'd3, 8'd2);
        drive(0, 1, 2'd2, 8'h38);
        drive(1, 0, 2'd0, 8'd0);
        drive(1, 1, 2'd2, 8'h38);
        checks++; if (gate_out !== 1'b1) begin errors++; $display("FAIL coll_expiry_gate got=%b exp=1", gate_out); end
        checks++; if (lut_addr_out !== 5'd0) begin errors++; $display("FAIL coll_expiry_lut got=%0d exp=0", lut_addr_out); end
        drive(1, 0, 2'd0, 8'd0);
        checks++; if (gate_out !== 1'b1) begin errors++; $display("FAIL coll_reload1 got=%b exp=1", gate_out); end
        drive(1, 0, 2'd0, 8'd0);
        checks++; if (gate_out !== 1'b0) begin errors++; $display("FAIL coll_reload2 got=%b exp=0", gate_out); end
    endtask

    task automatic test_enable_mute();
        drive(0, 1, 2'd2, 8'h28);
        for (int k = 0; k < 3; k++) drive(1, 0, 2'd0, 8'd0);
        checks++; if (lut_addr_out !== 5'd3) begin errors++; $display("FAIL mute_pre got=%0d exp=3", lut_addr_out); end
        drive(0, 1, 2'd2, 8'h00);
        checks++; if (gate_out !== 1'b0) begin errors++; $display("FAIL mute_gate got=%b exp=0", gate_out); end
        drive(1, 0, 2'd0, 8'd0);
        drive(1, 0, 2'd0, 8'd0);
        checks++; if (lut_addr_out !== 5'd5) begin errors++; $display("FAIL mute_advance got=%0d exp=5", lut_addr_out); end
        drive(0, 1, 2'd2, 8'h08);
        checks++; if (gate_out !== 1'b1) begin errors++; $display("FAIL unmute_gate got=%b exp=1", gate_out); end
        drive(1, 0, 2'd0, 8'd0);
        checks++; if (lut_addr_out !== 5'd6) begin errors++; $display("FAIL unmute_phase got=%0d exp=6", lut_addr_out); end
    endtask

    task automatic test_reset_midrun();
        #2;
        reset_n_in = 1'b0;
        #1;
        model_reset();
        checks++; if (lut_addr_out !== 5'd0) begin errors++; $display("FAIL midreset_lut got=%0d exp=0", lut_addr_out); end
        checks++; if (gate_out !== 1'b0) begin errors++; $display("FAIL midreset_gate got=%b exp=0", gate_out); end
        checks++; if (wave_type_out !== 3'd0) begin errors++; $display("FAIL midreset_type got=%0d exp=0", wave_type_out); end
        @(negedge clk_in);
        @(negedge clk_in);
        reset_n_in = 1'b1;
        set_freq(16'h8000);
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 2'd0, 8'd0);
            checks++; if (lut_addr_out !== 5'd0) begin errors++; $display("FAIL midreset_idle got=%0d exp=0", lut_addr_out); end
        end
    endtask

    task automatic test_random();
        bit       t, we;
        bit [1:0] a;
        bit [7:0] d;
        for (int c = 0; c < 3000; c++) begin
            t  = ($urandom_range(0, 1) == 1);
            we = ($urandom_range(0, 3) == 0);
            a  = 2'($urandom_range(0, 3));
            d  = 8'($urandom);
            if (a == 2'd3) d = 8'($urandom_range(0, 6));
            if (a == 2'd2 && $urandom_range(0, 3) != 0) d[5] = 1'b0;
            if (a == 2'd1) d = 8'($urandom_range(0, 63));
            drive(t, we, a, d);
            checks++;
            if (lut_addr_out !== 5'((m_acc >> 15) & 31)) begin
                errors++; $display("FAIL rand_lut cyc=%0d got=%0d exp=%0d", c, lut_addr_out, (m_acc >> 15) & 31);
            end
            checks++;
            if (gate_out !== (m_en && m_active)) begin
                errors++; $display("FAIL rand_gate cyc=%0d got=%b exp=%b", c, gate_out, (m_en && m_active));
            end
            checks++;
            if (wrap_out !== m_wrap) begin
                errors++; $display("FAIL rand_wrap cyc=%0d got=%b exp=%b", c, wrap_out, m_wrap);
            end
            checks++;
            if (wave_type_out !== 3'(m_type)) begin
                errors++; $display("FAIL rand_type cyc=%0d got=%0d exp=%0d", c, wave_type_out, m_type);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rate();
        test_atomic_freq();
        test_length();
        test_collisions();
        test_enable_mute();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
